msg_scroller: RTL and testbench

MSG_SCROLLER -- requirements
Module: msg_scroller

---
 rtl/msg_scroller.sv | 181 ++++++++++++++++++
 tb/tb_msg_scroller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroller.sv
// Scrolling message display: a character buffer shown through a sliding window that wraps and pauses.
// Optional build macro SCROLL_BLINK_EN adds a blink_en input that blinks the display while paused.
module msg_scroller #(
  parameter int MAX_LEN      = 32,
  parameter int CHAR_WIDTH   = 8,
  parameter int NUM_DISPLAYS = 6,
  parameter int PAUSE_TICKS  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   tick,
  input  logic                                   wr_en,
  input  logic [$clog2(MAX_LEN)-1:0]             wr_addr,
  input  logic [CHAR_WIDTH-1:0]                  wr_data,
  input  logic                                   len_wr,
  input  logic [$clog2(MAX_LEN+1)-1:0]           len_in,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   scroll_dir,
`ifdef SCROLL_BLINK_EN
  input  logic                                   blink_en,
`endif
  output logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] display_chars,
  output logic                                   busy,
  output logic                                   wrap
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(PAUSE_TICKS + 1);
  localparam logic [LW-1:0]         MAX_LEN_L  = LW'(MAX_LEN);
  localparam logic [AW:0]           ADDR_LIM   = (AW+1)'(MAX_LEN);
  localparam logic [PW-1:0]         PAUSE_LAST = PW'(PAUSE_TICKS - 1);
  localparam logic [CHAR_WIDTH-1:0] BLANK      = CHAR_WIDTH'(8'h20);

  typedef enum logic [1:0] {IDLE, SCROLL, PAUSE} state_t;

  state_t                                 state_q;
  logic [AW-1:0]                          idx_q;
  logic [LW-1:0]                          len_q;
  logic [PW-1:0]                          pcnt_q;
  logic                                   wrap_q;
  logic                                   blink_q;
  logic [CHAR_WIDTH-1:0]                  mem_q [MAX_LEN];
  logic [NUM_DISPLAYS-1:0][CHAR_WIDTH-1:0] disp_q, disp_d;

  logic [LW-1:0] len_d;
  logic [LW-1:0] idx_ext, idx_inc;
  logic [AW-1:0] idx_d;
  logic          step_wrap;

  always_comb begin
    len_d = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;
  end

  // Next index for one step in the current direction, and whether that step wraps.
  always_comb begin
    idx_ext   = LW'(idx_q);
    idx_inc   = idx_ext + 1'b1;
    idx_d     = idx_q;
    step_wrap = 1'b0;
    if (!scroll_dir) begin
      if (idx_inc == len_q) begin
        idx_d     = '0;
        step_wrap = 1'b1;
      end else begin
        idx_d = AW'(idx_inc);
      end
    end else begin
      if (idx_q == '0) begin
        idx_d     = AW'(len_q - 1'b1);
        step_wrap = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      pcnt_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (state_q == IDLE && len_wr) begin
        len_q <= len_d;
      end
      if (stop) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && len_q != '0) begin
              state_q <= SCROLL;
              idx_q   <= '0;
            end
          end
          SCROLL: begin
            if (tick) begin
              idx_q <= idx_d;
              if (step_wrap) begin
                wrap_q  <= 1'b1;
                state_q <= PAUSE;
                pcnt_q  <= '0;
              end
            end
          end
          PAUSE: begin
            if (tick) begin
              if (pcnt_q == PAUSE_LAST) begin
                state_q <= SCROLL;
                pcnt_q  <= '0;
              end else begin
                pcnt_q <= pcnt_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SCROLL_BLINK_EN
  // Phase stays clear outside PAUSE, so it is always 0 on entry and cleared on any exit.
  always_ff @(posedge clk) begin
    if (rst || stop || state_q != PAUSE) begin
      blink_q <= 1'b0;
    end else if (tick) begin
      if (pcnt_q == PAUSE_LAST) begin
        blink_q <= 1'b0;
      end else if (blink_en) begin
        blink_q <= ~blink_q;
      end
    end
  end
`else
  assign blink_q = 1'b0;
`endif

  // Buffer is deliberately not reset so its contents survive a restart.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < ADDR_LIM)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // index + i is below 2*msg_len whenever i < msg_len, so one subtract keeps it in range.
  always_comb begin
    int p;
    p      = 0;
    disp_d = '0;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      p = int'(idx_q) + i;
      if (p >= int'(len_q)) begin
        p = p - int'(len_q);
      end
      if (blink_q || i >= int'(len_q)) begin
        disp_d[i] = BLANK;
      end else begin
        disp_d[i] = mem_q[p[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= {NUM_DISPLAYS{BLANK}};
    end else begin
      disp_q <= disp_d;
    end
  end

  assign display_chars = disp_q;
  assign busy          = (state_q != IDLE);
  assign wrap          = wrap_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Scoreboard bench for msg_scroller: stimulus queues expected display/busy/wrap state,
// a negedge monitor pops and compares.
module tb_msg_scroller;
  localparam int MAX_LEN = 32;
  localparam int CW      = 8;
  localparam int ND      = 6;
  localparam int PT      = 4;
  localparam int AW      = $clog2(MAX_LEN);
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic          len_wr = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          scroll_dir = 1'b0;
`ifdef SCROLL_BLINK_EN
  logic          blink_en = 1'b0;
`endif
  logic [ND-1:0][CW-1:0] display_chars;
  logic          busy;
  logic          wrap;

  msg_scroller #(
    .MAX_LEN(MAX_LEN), .CHAR_WIDTH(CW), .NUM_DISPLAYS(ND), .PAUSE_TICKS(PT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .len_wr(len_wr), .len_in(len_in), .start(start),
    .stop(stop), .scroll_dir(scroll_dir),
`ifdef SCROLL_BLINK_EN
    .blink_en(blink_en),
`endif
    .display_chars(display_chars), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [ND*CW-1:0]  disp;
    logic              busy;
    logic              wrap;
    int                wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wrap_cnt = 0;

  function automatic logic [ND*CW-1:0] s2d(input string s);
    logic [ND-1:0][CW-1:0] d;
    for (int i = 0; i < ND; i++) d[i] = CW'(s[i]);
    return d;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wrap === 1'b1) wrap_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (display_chars !== e.disp) begin
        n_bad++;
        $display("FAIL %s display: got %h want %h", e.name, display_chars, e.disp);
      end
      n_cmp++;
      if (busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy);
      end
      n_cmp++;
      if (wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL %s wrap: got %b want %b", e.name, wrap, e.wrap);
      end
      n_cmp++;
      if (wrap_cnt != e.wcnt) begin
        n_bad++;
        $display("FAIL %s wrap_count: got %0d want %0d", e.name, wrap_cnt, e.wcnt);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input string s, input logic b, input int wc);
    exp_t e;
    e.name = name;
    e.disp = s2d(s);
    e.busy = b;
    e.wrap = 1'b0;
    e.wcnt = wc;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input byte c);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = CW'(c);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load_len(input int n);
    len_wr = 1'b1; len_in = LW'(n);
    cyc();
    len_wr = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    string msg;
    msg = "HELLO 1234 ";
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("reset", "      ", 1'b0, 0);
    pulse_start();
    chk("start_len0", "      ", 1'b0, 0);

    for (int i = 0; i < 11; i++) wr(i, msg[i]);
    load_len(11);
    chk("idle_len11", "HELLO ", 1'b0, 0);
    pulse_start();
    chk("scroll_start", "HELLO ", 1'b1, 0);
    do_tick();
    chk("tick1", "ELLO 1", 1'b1, 0);
    repeat (9) do_tick();
    chk("tick10", " HELLO", 1'b1, 0);
    do_tick();
    chk("tick11_wrap", "HELLO ", 1'b1, 1);
    repeat (3) do_tick();
    chk("pause3", "HELLO ", 1'b1, 1);
    do_tick();
    chk("pause4", "HELLO ", 1'b1, 1);
    do_tick();
    chk("resume_step", "ELLO 1", 1'b1, 1);
    pulse_stop();
    chk("stop_keeps_idx", "ELLO 1", 1'b0, 1);

    wr(30, "Y");
    wr(31, "Z");
    load_len(40);
    scroll_dir = 1'b1;
    pulse_start();
    do_tick();
    chk("clamp_dir1_wrap", "ZHELLO", 1'b1, 2);
    len_wr = 1'b1; len_in = LW'(3);
    cyc();
    len_wr = 1'b0;
    repeat (4) do_tick();
    chk("busy_lenwr_pause", "ZHELLO", 1'b1, 2);
    do_tick();
    chk("busy_lenwr_step", "YZHELL", 1'b1, 2);
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    cyc();
    chk("start_stop", "YZHELL", 1'b0, 2);

    wr(0, "A");
    wr(1, "B");
    wr(2, "C");
    load_len(3);
    scroll_dir = 1'b0;
    pulse_start();
    chk("abc_start", "ABC   ", 1'b1, 2);
    do_tick();
    chk("abc_fwd", "BCA   ", 1'b1, 2);
    scroll_dir = 1'b1;
    do_tick();
    chk("abc_dirflip", "ABC   ", 1'b1, 2);
    do_tick();
    chk("abc_dir1_wrap", "CAB   ", 1'b1, 3);
    do_tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_pause", "      ", 1'b0, 3);
    load_len(3);
    chk("readback", "ABC   ", 1'b0, 3);
    pulse_start();
    chk("restart", "ABC   ", 1'b1, 3);

`ifdef SCROLL_BLINK_EN
    blink_en = 1'b1;
    do_tick();
    chk("blink_entry", "CAB   ", 1'b1, 4);
    do_tick();
    chk("blink1", "      ", 1'b1, 4);
    do_tick();
    chk("blink2", "CAB   ", 1'b1, 4);
    do_tick();
    chk("blink3", "      ", 1'b1, 4);
    do_tick();
    chk("blink_exit", "CAB   ", 1'b1, 4);
    blink_en = 1'b0;
`else
    do_tick();
    chk("pause_entry", "CAB   ", 1'b1, 4);
    do_tick();
    chk("pause_static", "CAB   ", 1'b1, 4);
`endif

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
